// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// Shared types and constants for the UART transmit FIFO controller.
package uart_tx_fifo_ctrl_pkg;

  localparam int DEPTH_W = 9;

  // FIFO strobes are active-low
  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    HOLD
  } rd_state_e;

endpackage

// File: rtl/uart_tx_fifo_ctrl_fifo_occ_counter.sv
// Committed-occupancy counter for the transmit FIFO, with registered
// almost-full flag that moves in the same cycle as the count.
module fifo_occ_counter
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] count,
  output logic               almost_full
);

  logic [DEPTH_W-1:0] count_next;

  // Next count: flush wins, simultaneous inc/dec cancel, clamp at both ends
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (inc && !dec && (count < DEPTH_W'(DEPTH))) begin
      count_next = count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count_next = count - 1'b1;
    end
  end

  // Count and flag registers; flag derived from next count to stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_next;
      almost_full <= (count_next >= DEPTH_W'(AF_LEVEL));
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit FIFO controller: registers host writes into the FIFO, pops bytes
// with read-latency compensation and offers them on a valid/ready handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | nothing in flight; pop when count > 0 and FIFO not empty
// READ  | FIFO_RDB low for exactly this cycle; count drops at its end
// WAIT  | RD_LAT cycles for the FIFO data; capture on the last one
// HOLD  | TX_VALID high, TX_DATA stable until TX_READY
module uart_tx_fifo_ctrl
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = 255,
  parameter int RD_LAT   = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               CLR,
  input  logic               WR_REQ,
  input  logic [7:0]         WR_DATA,
  output logic               OVERFLOW,
  output logic               FIFO_WRB,
  output logic [7:0]         FIFO_DI,
  output logic               FIFO_RDB,
  input  logic [7:0]         FIFO_DO,
  input  logic               FIFO_FULL,
  input  logic               FIFO_EMPTY,
  output logic               FIFO_RESET_N,
  output logic               TX_VALID,
  output logic [7:0]         TX_DATA,
  input  logic               TX_READY,
  output logic [DEPTH_W-1:0] COUNT,
  output logic               ALMOST_FULL
);

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  rd_state_e         state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fifo_ready;
  logic              wr_acc;
  logic              capture;

  assign fifo_ready = (COUNT != '0) && !FIFO_EMPTY;
  assign wr_acc     = WR_REQ && !CLR && (COUNT < DEPTH_W'(DEPTH)) && !FIFO_FULL;
  assign capture    = (state == WAIT) && (wait_cnt == '0);
  assign TX_VALID   = (state == HOLD);

  // Read FSM next-state decode; flush forces IDLE from any state
  always_comb begin
    state_next = state;
    if (CLR) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (fifo_ready) state_next = READ;
        READ:    state_next = WAIT;
        WAIT:    if (wait_cnt == '0) state_next = HOLD;
        HOLD:    if (TX_READY) state_next = fifo_ready ? READ : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register, latency down-counter and registered read strobe
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      wait_cnt <= '0;
      FIFO_RDB <= DEASSERT_N;
    end else begin
      state    <= state_next;
      FIFO_RDB <= (state_next == READ) ? ASSERT_N : DEASSERT_N;
      if (state == READ) begin
        wait_cnt <= WAIT_W'(RD_LAT - 1);
      end else if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // Write register stage and drop reporting; writes during flush are silent
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FIFO_WRB <= DEASSERT_N;
      FIFO_DI  <= 8'h00;
      OVERFLOW <= 1'b0;
    end else begin
      FIFO_WRB <= wr_acc ? ASSERT_N : DEASSERT_N;
      if (wr_acc) FIFO_DI <= WR_DATA;
      OVERFLOW <= WR_REQ && !CLR && !wr_acc;
    end
  end

  // FIFO reset: held during system reset, one-cycle pulse on flush
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FIFO_RESET_N <= ASSERT_N;
    end else begin
      FIFO_RESET_N <= CLR ? ASSERT_N : DEASSERT_N;
    end
  end

  // TX holding register, loaded when the FIFO output is valid
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      TX_DATA <= 8'h00;
    end else if (capture && !CLR) begin
      TX_DATA <= FIFO_DO;
    end
  end

  fifo_occ_counter #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_occ (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .clr         (CLR),
    .inc         (wr_acc),
    .dec         (state == READ),
    .count       (COUNT),
    .almost_full (ALMOST_FULL)
  );

endmodule
